mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit memory words, word-addressed.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles inserted between request acceptance and ack, range 0..15.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 f_req  input  1  instruction-fetch request, level, held until f_ack.
REQ-006 f_addr  input  8  fetch word address (program counter).
REQ-007 f_ack  output  1  one-cycle fetch completion pulse.
REQ-008 f_data  output  32  fetched instruction, valid with f_ack, held until the next f_ack.
REQ-009 d_req  input  1  data request, level, held until d_ack.
REQ-010 d_rw  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  16  data word address.
REQ-012 d_wdata  input  32  write data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  32  read data, valid with d_ack, held until the next d_ack.
REQ-015 d_err  output  1  out-of-range flag, pulses only together with d_ack.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT, and RESP.
REQ-018 In IDLE, if d_req=1, the block SHALL accept the data request, latching d_rw, d_addr, and d_wdata; otherwise, if f_req=1, it SHALL accept the fetch request, latching f_addr. Data SHALL have priority over fetch.
REQ-019 On acceptance, the FSM SHALL go to WAIT and load the counter with WAIT_STATES; if WAIT_STATES=0, it SHALL go directly to RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle; on reaching 1, the FSM SHALL go to RESP.
REQ-021 In RESP, the block SHALL assert the ack of the accepted port for exactly one cycle, perform the array access, and return to IDLE.
REQ-022 Latency SHALL be WAIT_STATES+1 cycles: a request sampled at edge t SHALL produce ack high during cycle t+1+WAIT_STATES.
REQ-023 A write SHALL commit to the array at the edge that ends the RESP cycle.
REQ-024 Read data SHALL reflect all writes committed before the RESP cycle.
REQ-025 A request still high in the IDLE cycle after its ack SHALL be treated as a new request; the requester SHALL drop req in the ack cycle.
REQ-026 A fetch request pending while a data request is served SHALL be accepted in the IDLE cycle following the data ack, provided no new d_req is present. No fetch starvation guarantee is given beyond this.
REQ-027 A request deassertion during WAIT SHALL NOT abort the transaction; it SHALL complete using the latched values.
REQ-028 If d_addr >= DEPTH, a write SHALL be discarded, a read SHALL return 0, and d_err SHALL be set to 1 in the ack cycle.
REQ-029 If f_addr >= DEPTH, f_data SHALL be set to 0. The fetch port has no error output.
REQ-030 Only the low log2(DEPTH) address bits SHALL index the array.
REQ-031 Both acks SHALL never be high in the same cycle.

Reset
REQ-032 When reset=1, the FSM SHALL go to IDLE; the counter, f_ack, d_ack, d_err, and busy SHALL be set to 0; and f_data and d_rdata SHALL be set to 0.
REQ-033 Reset during WAIT or RESP SHALL abort the transaction: no ack SHALL be issued and no write SHALL commit.
REQ-034 Array contents SHALL NOT be cleared by reset.
REQ-035 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-036 The shared package mem_pkg SHALL hold the state enumeration, the RW_WRITE and RW_READ constants, and the DEPTH and WAIT_STATES defaults.
REQ-037 The storage SHALL be a sub-module mem_array_sp: a single-port synchronous array with write enable, address, write data, and read data.
REQ-038 The FSM, arbitration, counter, and output registers SHALL reside in mem_responder.

Verification
REQ-039 WAIT_STATES=1: write 0xDEADBEEF to d_addr 5 -> d_ack in cycle t+2; then a read of d_addr 5 -> d_rdata=0xDEADBEEF and d_err=0.
REQ-040 Same-cycle d_req (read addr 3) and f_req (addr 7) -> d_ack first; f_ack exactly 3 cycles later with the word at 7; acks never coincide.
REQ-041 Read of d_addr 0x0100 with DEPTH=256 -> d_rdata=0 and d_err=1 with d_ack. Write of 0x11111111 to d_addr 0x0105 -> the word at 5 is unchanged.
REQ-042 Reset asserted during WAIT of a write of 0xCAFEF00D to addr 9 -> no d_ack, busy=0 the next cycle, and the word at 9 retains its old value.
REQ-043 WAIT_STATES=0 with back-to-back fetches of addr 0, 1, 2 and req held continuously -> one f_ack every 2 cycles, returning the correct words in order.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its storage array.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int DEPTH_DEFAULT       = 256;
    localparam int WAIT_STATES_DEFAULT = 1;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word array with registered read; contents are never reset.
module mem_array_sp #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_array [DEPTH];

    // Read-first: rdata shows the word as it was before a same-edge write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[addr] <= wdata;
        end
        rdata <= mem_array[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Two-port (fetch/data) memory responder with data priority and fixed wait states.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [7:0]  f_addr,
    output logic        f_ack,
    output logic [31:0] f_data,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [15:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);

    localparam int         ADDR_W = $clog2(DEPTH);
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        is_data_reg;
    logic        rw_reg;
    logic [15:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        f_ack_reg;
    logic [31:0] f_data_reg;
    logic        d_ack_reg;
    logic [31:0] d_rdata_reg;
    logic        d_err_reg;
    logic        busy_reg;

    logic [15:0]       idle_addr;
    logic [ADDR_W-1:0] arr_addr;
    logic [31:0]       arr_rdata;
    logic              in_range;
    logic              arr_we;

    // While idle the array already looks at the incoming address, so the word
    // is ready in RESP even when RESP directly follows acceptance.
    assign idle_addr = d_req ? d_addr : {8'd0, f_addr};
    assign arr_addr  = (state_reg == IDLE) ? idle_addr[ADDR_W-1:0] : addr_reg[ADDR_W-1:0];
    assign in_range  = {16'd0, addr_reg} < 32'(DEPTH);
    assign arr_we    = (state_reg == RESP) && is_data_reg && (rw_reg == RW_WRITE)
                       && in_range && !reset;

    mem_array_sp #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_reg),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            is_data_reg <= 1'b0;
            rw_reg      <= RW_READ;
            addr_reg    <= 16'd0;
            wdata_reg   <= 32'd0;
            f_ack_reg   <= 1'b0;
            f_data_reg  <= 32'd0;
            d_ack_reg   <= 1'b0;
            d_rdata_reg <= 32'd0;
            d_err_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            f_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;
            d_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (d_req || f_req) begin
                        is_data_reg <= d_req;
                        rw_reg      <= d_req ? d_rw : RW_READ;
                        addr_reg    <= idle_addr;
                        wdata_reg   <= d_wdata;
                        cnt_reg     <= WS;
                        busy_reg    <= 1'b1;
                        state_reg   <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (is_data_reg) begin
                        d_ack_reg <= 1'b1;
                        d_err_reg <= !in_range;
                        if (rw_reg == RW_READ) begin
                            d_rdata_reg <= in_range ? arr_rdata : 32'd0;
                        end
                    end else begin
                        f_ack_reg  <= 1'b1;
                        f_data_reg <= in_range ? arr_rdata : 32'd0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign f_ack   = f_ack_reg;
    assign f_data  = f_data_reg;
    assign d_ack   = d_ack_reg;
    assign d_rdata = d_rdata_reg;
    assign d_err   = d_err_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance a runs one wait state, instance b runs zero wait states.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        f_req_a, f_ack_a, d_req_a, d_rw_a, d_ack_a, d_err_a, busy_a;
    logic [7:0]  f_addr_a;
    logic [15:0] d_addr_a;
    logic [31:0] f_data_a, d_wdata_a, d_rdata_a;

    logic        f_req_b, f_ack_b, d_req_b, d_rw_b, d_ack_b, d_err_b, busy_b;
    logic [7:0]  f_addr_b;
    logic [15:0] d_addr_b;
    logic [31:0] f_data_b, d_wdata_b, d_rdata_b;

    mem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .f_req(f_req_a), .f_addr(f_addr_a), .f_ack(f_ack_a), .f_data(f_data_a),
        .d_req(d_req_a), .d_rw(d_rw_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .d_ack(d_ack_a), .d_rdata(d_rdata_a), .d_err(d_err_a), .busy(busy_a)
    );

    mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .f_req(f_req_b), .f_addr(f_addr_b), .f_ack(f_ack_b), .f_data(f_data_b),
        .d_req(d_req_b), .d_rw(d_rw_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b), .d_err(d_err_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One data transaction on instance a (sel_b=0) or b (sel_b=1); lat counts edges
    // from the accepting edge up to and including the edge that raises d_ack.
    task automatic do_data(input bit sel_b, input logic rw, input logic [15:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat);
        logic ack;
        ack = 1'b0;
        lat = 0;
        if (sel_b) begin
            d_req_b = 1'b1; d_rw_b = rw; d_addr_b = addr; d_wdata_b = wdata;
        end else begin
            d_req_a = 1'b1; d_rw_a = rw; d_addr_a = addr; d_wdata_a = wdata;
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            ack = sel_b ? d_ack_b : d_ack_a;
            if (ack) break;
        end
        check("data_ack_timeout", 32'(ack), 32'd1);
        rdata = sel_b ? d_rdata_b : d_rdata_a;
        err   = sel_b ? d_err_b : d_err_a;
        if (sel_b) d_req_b = 1'b0; else d_req_a = 1'b0;
        $display("txn dut=%s rw=%0d addr=0x%04h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d",
                 sel_b ? "b" : "a", rw, addr, wdata, rdata, err, lat);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          dt, ft, both, idx, stray;
    logic [31:0] dv, fv;
    logic [31:0] fexp [3];

    initial begin
        reset = 1'b1;
        f_req_a = 0; f_addr_a = 0; d_req_a = 0; d_rw_a = 0; d_addr_a = 0; d_wdata_a = 0;
        f_req_b = 0; f_addr_b = 0; d_req_b = 0; d_rw_b = 0; d_addr_b = 0; d_wdata_b = 0;
        repeat (3) tick();

        check("rst_f_ack",   32'(f_ack_a), 32'd0);
        check("rst_d_ack",   32'(d_ack_a), 32'd0);
        check("rst_d_err",   32'(d_err_a), 32'd0);
        check("rst_busy",    32'(busy_a),  32'd0);
        check("rst_f_data",  f_data_a,     32'd0);
        check("rst_d_rdata", d_rdata_a,    32'd0);
        check("rst_busy_b",  32'(busy_b),  32'd0);
        reset = 1'b0;
        tick();

        // Write then read back at address 5, one wait state.
        do_data(0, RW_WRITE, 16'd5, 32'hDEADBEEF, rd, er, lat);
        check("wr5_lat", 32'(lat), 32'd3);
        check("wr5_err", 32'(er), 32'd0);
        do_data(0, RW_READ, 16'd5, 32'd0, rd, er, lat);
        check("rd5_data", rd, 32'hDEADBEEF);
        check("rd5_err", 32'(er), 32'd0);
        check("rd5_lat", 32'(lat), 32'd3);
        tick();
        check("rd5_ack_pulse", 32'(d_ack_a), 32'd0);
        check("rd5_hold", d_rdata_a, 32'hDEADBEEF);
        check("rd5_idle_busy", 32'(busy_a), 32'd0);

        do_data(0, RW_WRITE, 16'd3, 32'hA5A5A5A5, rd, er, lat);
        do_data(0, RW_WRITE, 16'd7, 32'h12345678, rd, er, lat);
        do_data(0, RW_WRITE, 16'd9, 32'h0BADF00D, rd, er, lat);

        // Simultaneous data read and fetch: data first, fetch three cycles later.
        d_req_a = 1'b1; d_rw_a = RW_READ; d_addr_a = 16'd3;
        f_req_a = 1'b1; f_addr_a = 8'd7;
        dt = 0; ft = 0; both = 0; dv = 0; fv = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (d_ack_a && f_ack_a) both++;
            if (d_ack_a) begin dt = i; d_req_a = 1'b0; dv = d_rdata_a; end
            if (f_ack_a) begin ft = i; f_req_a = 1'b0; fv = f_data_a; end
            if (ft != 0) break;
        end
        f_req_a = 1'b0; d_req_a = 1'b0;
        $display("txn dut=a arb d_ack@%0d f_ack@%0d d_rdata=0x%08h f_data=0x%08h", dt, ft, dv, fv);
        check("arb_d_lat", 32'(dt), 32'd3);
        check("arb_f_gap", 32'(ft - dt), 32'd3);
        check("arb_d_data", dv, 32'hA5A5A5A5);
        check("arb_f_data", fv, 32'h12345678);
        check("arb_no_overlap", 32'(both), 32'd0);

        // Out-of-range read and write.
        do_data(0, RW_READ, 16'h0100, 32'd0, rd, er, lat);
        check("oor_rd_data", rd, 32'd0);
        check("oor_rd_err", 32'(er), 32'd1);
        tick();
        check("oor_err_pulse", 32'(d_err_a), 32'd0);
        do_data(0, RW_WRITE, 16'h0105, 32'h11111111, rd, er, lat);
        check("oor_wr_err", 32'(er), 32'd1);
        do_data(0, RW_READ, 16'd5, 32'd0, rd, er, lat);
        check("oor_wr_alias", rd, 32'hDEADBEEF);
        check("oor_after_err", 32'(er), 32'd0);

        // Reset in WAIT of a write aborts it.
        d_req_a = 1'b1; d_rw_a = RW_WRITE; d_addr_a = 16'd9; d_wdata_a = 32'hCAFEF00D;
        tick();
        check("abort_busy_wait", 32'(busy_a), 32'd1);
        reset = 1'b1; d_req_a = 1'b0;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_no_ack", 32'(d_ack_a), 32'd0);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d_ack_a) stray++;
        end
        check("abort_no_late_ack", 32'(stray), 32'd0);
        do_data(0, RW_READ, 16'd9, 32'd0, rd, er, lat);
        check("abort_word9", rd, 32'h0BADF00D);

        // Zero wait states: back-to-back fetches with req held.
        fexp[0] = 32'h10000000; fexp[1] = 32'h20000001; fexp[2] = 32'h30000002;
        for (int k = 0; k < 3; k++) begin
            do_data(1, RW_WRITE, 16'(k), fexp[k], rd, er, lat);
            check("b_wr_lat", 32'(lat), 32'd2);
        end
        f_req_b = 1'b1; f_addr_b = 8'd0; idx = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (f_ack_b) begin
                $display("txn dut=b fetch addr=%0d f_data=0x%08h at edge %0d", idx, f_data_b, i);
                check("b_fetch_data", f_data_b, fexp[idx]);
                check("b_fetch_time", 32'(i), 32'(2 * (idx + 1)));
                idx++;
                if (idx == 3) begin
                    f_req_b = 1'b0;
                    break;
                end
                f_addr_b = 8'(idx);
            end
        end
        f_req_b = 1'b0;
        check("b_fetch_count", 32'(idx), 32'd3);
        tick();
        check("b_fetch_pulse", 32'(f_ack_b), 32'd0);
        check("b_fetch_hold", f_data_b, 32'h30000002);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
